// File: rtl/pixel_stream_proc_if.sv
// Pixel stream bundle: an input stream into the processor and an output stream
// out of it, each carrying one RGB pixel per beat.
interface pixel_stream_proc_if #(
  parameter int PIX_W = 8,
  parameter int DIM_W = 11
) ();
  // Both streams are valid/ready: a beat transfers on a rising edge where valid
  // and ready are both high; while valid is high and ready low, the producer
  // keeps valid and the payload unchanged. Ready may depend on the other side.
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_r;
  logic [PIX_W-1:0] in_g;
  logic [PIX_W-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_r;
  logic [PIX_W-1:0] out_g;
  logic [PIX_W-1:0] out_b;
  logic [DIM_W-1:0] out_row;
  logic [DIM_W-1:0] out_col;
  logic             out_last;

  modport slave (
    input  in_valid, in_r, in_g, in_b, out_ready,
    output in_ready, out_valid, out_r, out_g, out_b, out_row, out_col, out_last
  );

  modport master (
    output in_valid, in_r, in_g, in_b, out_ready,
    input  in_ready, out_valid, out_r, out_g, out_b, out_row, out_col, out_last
  );
endinterface

// File: rtl/pixel_stream_proc.sv
// Frame-based pixel processor: a two-stage pipeline applying a per-frame colour
// operation and tagging each output pixel with its raster position.
module pixel_stream_proc #(
  parameter int PIX_W = 8,
  parameter int DIM_W = 11
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                start,
  input  logic [2:0]          cfg_mode,
  input  logic [PIX_W-1:0]    cfg_value,
  input  logic [DIM_W-1:0]    cfg_width,
  input  logic [DIM_W-1:0]    cfg_height,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg,
  pixel_stream_proc_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [DIM_W-1:0] ONE_D = 1;
  localparam logic [PIX_W+1:0] THREE = 3;

  state_t state, state_nxt;

  logic [2:0]       mode_q;
  logic [PIX_W-1:0] value_q;
  logic [DIM_W-1:0] width_q, height_q;
  logic [DIM_W-1:0] in_row, in_col;

  logic             s1_valid, s1_last;
  logic [PIX_W-1:0] s1_r, s1_g, s1_b;
  logic [DIM_W-1:0] s1_row, s1_col;
  logic             s2_valid, s2_last;
  logic [PIX_W-1:0] s2_r, s2_g, s2_b;
  logic [DIM_W-1:0] s2_row, s2_col;

  logic             s1_adv, s2_adv, in_ready, in_fire, in_end;
  logic             idle_start, start_ok, start_zero, last_fire;
  logic [PIX_W+1:0] sum3, quot;
  logic [PIX_W-1:0] gray;

  function automatic logic [PIX_W-1:0] pix_op(input logic [2:0] m,
                                              input logic [PIX_W-1:0] c,
                                              input logic [PIX_W-1:0] v,
                                              input logic [PIX_W-1:0] g);
    logic [PIX_W:0] sum;
    sum = {1'b0, c} + {1'b0, v};
    pix_op = c;
    case (m)
      3'd1:    pix_op = sum[PIX_W] ? '1 : sum[PIX_W-1:0];
      3'd2:    pix_op = (c < v) ? '0 : c - v;
      3'd3:    pix_op = g;
      3'd4:    pix_op = (g > v) ? '1 : '0;
      3'd5:    pix_op = ~c;
      default: pix_op = c;
    endcase
  endfunction

  // Stage 2 frees up when empty or draining; stage 1 when empty or moving on.
  assign s2_adv     = !s2_valid || bus.out_ready;
  assign s1_adv     = !s1_valid || s2_adv;
  assign in_ready   = (state == RUN) && s1_adv;
  assign in_fire    = bus.in_valid && in_ready;
  assign in_end     = (in_row == height_q - ONE_D) && (in_col == width_q - ONE_D);
  assign idle_start = (state == IDLE) && start;
  assign start_zero = idle_start && ((cfg_width == '0) || (cfg_height == '0));
  assign start_ok   = idle_start && !start_zero;
  assign last_fire  = (state == FLUSH) && s2_valid && s2_last && bus.out_ready;

  always_comb begin
    sum3 = {2'b00, s1_r} + {2'b00, s1_g} + {2'b00, s1_b};
    quot = sum3 / THREE;
    gray = quot[PIX_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (in_fire && in_end) state_nxt = FLUSH;
      FLUSH:   if (last_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      done     <= 1'b0;
      mode_q   <= '0;
      value_q  <= '0;
      width_q  <= '0;
      height_q <= '0;
      in_row   <= '0;
      in_col   <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_row   <= '0;
      s1_col   <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_r     <= '0;
      s2_g     <= '0;
      s2_b     <= '0;
      s2_row   <= '0;
      s2_col   <= '0;
    end else begin
      done <= start_zero || last_fire;
      if (idle_start) begin
        mode_q   <= cfg_mode;
        value_q  <= cfg_value;
        width_q  <= cfg_width;
        height_q <= cfg_height;
        in_row   <= '0;
        in_col   <= '0;
      end else if (in_fire) begin
        if (in_col == width_q - ONE_D) begin
          in_col <= '0;
          in_row <= in_end ? '0 : in_row + ONE_D;
        end else begin
          in_col <= in_col + ONE_D;
        end
      end
      if (s1_adv) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          s1_r    <= bus.in_r;
          s1_g    <= bus.in_g;
          s1_b    <= bus.in_b;
          s1_row  <= in_row;
          s1_col  <= in_col;
          s1_last <= in_end;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_r    <= pix_op(mode_q, s1_r, value_q, gray);
          s2_g    <= pix_op(mode_q, s1_g, value_q, gray);
          s2_b    <= pix_op(mode_q, s1_b, value_q, gray);
          s2_row  <= s1_row;
          s2_col  <= s1_col;
          s2_last <= s1_last;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.out_r     = s2_r;
  assign bus.out_g     = s2_g;
  assign bus.out_b     = s2_b;
  assign bus.out_row   = s2_row;
  assign bus.out_col   = s2_col;
  assign bus.out_last  = s2_valid && s2_last;
  assign busy          = (state == RUN);
  assign state_dbg     = state;

endmodule

// File: tb/tb_pixel_stream_proc.sv
// Bench for pixel_stream_proc: directed and randomized frames scored against a
// behavioural pixel model through an expected-output queue.
module tb_pixel_stream_proc;
  localparam int PIX_W = 8;
  localparam int DIM_W = 11;

  logic             HCLK = 1'b0;
  logic             HRESET;
  logic             start;
  logic [2:0]       cfg_mode;
  logic [PIX_W-1:0] cfg_value;
  logic [DIM_W-1:0] cfg_width, cfg_height;
  logic             busy, done;
  logic [1:0]       state_dbg;

  pixel_stream_proc_if #(.PIX_W(PIX_W), .DIM_W(DIM_W)) bus ();

  pixel_stream_proc #(.PIX_W(PIX_W), .DIM_W(DIM_W)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .start     (start),
    .cfg_mode  (cfg_mode),
    .cfg_value (cfg_value),
    .cfg_width (cfg_width),
    .cfg_height(cfg_height),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg),
    .bus       (bus)
  );

  // clock / watchdog
  always #5 HCLK = ~HCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [46:0] exp_q[$];

  int f_w, f_h, f_mode, f_val, n_tot, sent, recv;
  int fix_r, fix_g, fix_b;
  int first_acc, first_out, last_out, done_cyc, done_cnt;
  bit rnd_valid, rnd_ready, fix_en, post_chk, held_valid, acc_prev;
  logic [46:0] held_data;
  logic [23:0] first_rgb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: position from the pixel index, colour from the mode rules.
  function automatic logic [46:0] model(int idx, int r, int g, int b);
    int row, col, gray;
    int c[3];
    int o[3];
    row  = idx / f_w;
    col  = idx % f_w;
    gray = (r + g + b) / 3;
    c = '{r, g, b};
    for (int i = 0; i < 3; i++) begin
      case (f_mode)
        1:       o[i] = (c[i] + f_val > 255) ? 255 : c[i] + f_val;
        2:       o[i] = (c[i] < f_val) ? 0 : c[i] - f_val;
        3:       o[i] = gray;
        4:       o[i] = (gray > f_val) ? 255 : 0;
        5:       o[i] = 255 - c[i];
        default: o[i] = c[i];
      endcase
    end
    return {(idx == n_tot - 1) ? 1'b1 : 1'b0, 11'(row), 11'(col),
            8'(o[0]), 8'(o[1]), 8'(o[2])};
  endfunction

  function automatic logic [46:0] obs_out();
    return {bus.out_last, bus.out_row, bus.out_col, bus.out_r, bus.out_g, bus.out_b};
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 time unit later.
  task automatic step();
    logic [46:0] o, e;
    if (acc_prev) bus.in_valid = 1'b0;
    acc_prev = 1'b0;
    bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!bus.in_valid && sent < n_tot && (!rnd_valid || $urandom_range(0, 1) == 1)) begin
      bus.in_valid = 1'b1;
      bus.in_r = fix_en ? 8'(fix_r) : 8'($urandom_range(0, 255));
      bus.in_g = fix_en ? 8'(fix_g) : 8'($urandom_range(0, 255));
      bus.in_b = fix_en ? 8'(fix_b) : 8'($urandom_range(0, 255));
    end
    #1;
    o = obs_out();
    if (held_valid) check("hold_stable", {bus.out_valid, o}, {1'b1, held_data});
    held_valid = bus.out_valid && !bus.out_ready;
    held_data  = o;
    if (bus.out_valid && bus.out_ready) begin
      if (first_out < 0) begin
        first_out = cyc;
        first_rgb = o[23:0];
      end
      last_out = cyc;
      if (exp_q.size() == 0) begin
        check("output_without_input", 64'(exp_q.size()), 64'(1));
      end else begin
        e = exp_q.pop_front();
        check("pixel", o, e);
      end
      recv++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (n_tot > 0 && sent == n_tot && !post_chk) begin
      check("in_ready_after_last", bus.in_ready, 0);
      post_chk = 1'b1;
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(sent, bus.in_r, bus.in_g, bus.in_b));
      sent++;
      acc_prev = 1'b1;
      if (first_acc < 0) first_acc = cyc;
    end
    @(negedge HCLK);
    cyc++;
  endtask

  task automatic new_frame(int w, int h, int mode, int val, bit rv, bit rr);
    f_w = w; f_h = h; f_mode = mode; f_val = val;
    n_tot = w * h; sent = 0; recv = 0;
    first_acc = -1; first_out = -1; last_out = -1; done_cyc = -1; done_cnt = 0;
    post_chk = 1'b0; rnd_valid = rv; rnd_ready = rr;
    cfg_width = 11'(w); cfg_height = 11'(h); cfg_mode = 3'(mode); cfg_value = 8'(val);
  endtask

  task automatic run_frame(int w, int h, int mode, int val, bit rv, bit rr, bit mid_start);
    int k;
    new_frame(w, h, mode, val, rv, rr);
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while ((recv < n_tot || done_cnt == 0) && k < n_tot * 30 + 40) begin
      if (mid_start && k == 3) begin
        start = 1'b1; cfg_mode = 3'd5; cfg_width = 11'd2; cfg_height = 11'd1; cfg_value = 8'd7;
      end else begin
        start = 1'b0;
      end
      step();
      if (mid_start && k == 3) check("busy_during_ignored_start", busy, 1);
      k++;
    end
    start = 1'b0;
    check("frame_pixel_count", recv, n_tot);
    check("done_count", done_cnt, 1);
    check("done_after_last", done_cyc, last_out + 1);
  endtask

  initial begin
    HRESET = 1'b1; start = 1'b0;
    cfg_mode = '0; cfg_value = '0; cfg_width = '0; cfg_height = '0;
    bus.in_valid = 1'b0; bus.in_r = '0; bus.in_g = '0; bus.in_b = '0; bus.out_ready = 1'b1;
    n_tot = 0; sent = 0; fix_en = 1'b0; held_valid = 1'b0; acc_prev = 1'b0;
    rnd_valid = 1'b0; rnd_ready = 1'b0; f_w = 1; f_h = 1;

    // Reset state
    repeat (2) @(negedge HCLK);
    #1;
    check("reset_outputs",
          {bus.in_ready, bus.out_valid, bus.out_last, busy, done, state_dbg,
           bus.out_r, bus.out_g, bus.out_b, bus.out_row, bus.out_col}, 0);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);

    // 4x2 brighten frame, full throughput
    fix_en = 1'b1; fix_r = 200; fix_g = 50; fix_b = 155;
    run_frame(4, 2, 1, 100, 1'b0, 1'b0, 1'b0);
    check("first_latency", first_out - first_acc, 2);
    check("sustained_rate", last_out - first_out, 7);
    check("brighten_rgb", first_rgb, 24'hFF96FF);

    // Single-pixel mode examples
    fix_r = 10; fix_g = 20; fix_b = 31;
    run_frame(1, 1, 3, 0, 1'b0, 1'b0, 1'b0);
    check("gray_rgb", first_rgb, 24'h141414);
    run_frame(1, 1, 4, 19, 1'b0, 1'b0, 1'b0);
    check("threshold19_rgb", first_rgb, 24'hFFFFFF);
    run_frame(1, 1, 4, 20, 1'b0, 1'b0, 1'b0);
    check("threshold20_rgb", first_rgb, 24'h000000);
    fix_r = 50; fix_g = 100; fix_b = 101;
    run_frame(1, 1, 2, 100, 1'b0, 1'b0, 1'b0);
    check("darken_rgb", first_rgb, 24'h000001);
    fix_r = 0; fix_g = 255; fix_b = 15;
    run_frame(1, 1, 5, 0, 1'b0, 1'b0, 1'b0);
    check("invert_rgb", first_rgb, 24'hFF00F0);

    // 3x3 with random handshakes and an ignored start mid-frame
    fix_en = 1'b0;
    run_frame(3, 3, 1, $urandom_range(0, 255), 1'b1, 1'b1, 1'b1);

    // Random frames across all modes
    for (int i = 0; i < 8; i++) begin
      run_frame($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(0, 7),
                $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Zero-width start: done next cycle, never ready
    new_frame(1, 1, 0, 0, 1'b0, 1'b0);
    n_tot = 0;
    cfg_width = 11'd0; cfg_height = 11'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    check("zero_dim_done", done, 1);
    check("zero_dim_in_ready", bus.in_ready, 0);
    check("zero_dim_busy", busy, 0);
    @(negedge HCLK);
    #1;
    check("zero_dim_done_pulse", done, 0);
    @(negedge HCLK);

    // Reset after 4 of 9 pixels, then a fresh frame
    new_frame(3, 3, 0, 0, 1'b0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 60 && sent < 4; k++) step();
    check("pixels_before_abort", sent, 4);
    HRESET = 1'b1;
    #1;
    check("abort_outputs",
          {bus.in_ready, bus.out_valid, bus.out_last, busy, done, state_dbg,
           bus.out_r, bus.out_g, bus.out_b, bus.out_row, bus.out_col}, 0);
    exp_q.delete();
    held_valid = 1'b0; acc_prev = 1'b0; bus.in_valid = 1'b0;
    @(negedge HCLK);
    HRESET = 1'b0;
    n_tot = sent; done_cnt = 0;
    repeat (3) step();
    check("abort_no_done", done_cnt, 0);
    run_frame(2, 2, 5, 0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pixel_stream_proc.md
PIXEL_STREAM_PROC -- requirements
Module: pixel_stream_proc

Interface
REQ-001 Parameter PIX_W, default 8, bits per colour component.
REQ-002 Parameter DIM_W, default 11, bits of width/height/row/col.
REQ-003 Port HCLK  in  1  sole clock; all state on rising edge.
REQ-004 Port HRESET  in  1  reset, asynchronous, active-high.
REQ-005 Port start  in  1  frame start request, sampled in IDLE only.
REQ-006 Port cfg_mode  in  3  operation select, latched on accepted start.
REQ-007 Port cfg_value  in  PIX_W  brightness offset / threshold, latched on accepted start.
REQ-008 Port cfg_width, cfg_height  in  DIM_W each  frame dimensions, latched on accepted start.
REQ-009 Port in_valid  in  1; in_ready  out  1; in_r, in_g, in_b  in  PIX_W each  input pixel stream.
REQ-010 Port out_valid  out  1; out_ready  in  1; out_r, out_g, out_b  out  PIX_W each  output pixel stream.
REQ-011 Port out_row, out_col  out  DIM_W each  raster position of current output pixel.
REQ-012 Port out_last  out  1  high with final pixel of frame.
REQ-013 Port busy  out  1  high in RUN; done  out  1  one-cycle end-of-frame pulse.

Function
REQ-014 FSM states IDLE, RUN, FLUSH; IDLE->RUN on start; RUN->FLUSH when the last input pixel (width*height-th) is accepted; FLUSH->IDLE when the out_last pixel is accepted; done pulses on that IDLE entry cycle.
REQ-015 start with cfg_width==0 or cfg_height==0: no RUN; done pulses next cycle; in_ready stays 0.
REQ-016 start while busy or in FLUSH is ignored; latched cfg unchanged until next accepted start.
REQ-017 Input accepted only when in_valid && in_ready; in_ready = (state==RUN) && stage 1 can advance.
REQ-018 Two-stage pipeline; stage k advances when empty or downstream advances; no stall: out_valid exactly 2 cycles after acceptance, one pixel per cycle sustained.
REQ-019 While out_valid && !out_ready, out_r/g/b/row/col/last hold stable; no pixel dropped or duplicated.
REQ-020 out_col increments per output pixel, wraps to 0 at cfg_width-1 with out_row+1; both 0 for first pixel of every frame.
REQ-021 out_last = 1 exactly when out_row==cfg_height-1 and out_col==cfg_width-1.
REQ-022 Mode 0: pass-through.
REQ-023 Mode 1: each component + cfg_value, saturate to 2^PIX_W-1.
REQ-024 Mode 2: each component - cfg_value, saturate to 0.
REQ-025 Mode 3: gray = floor((r+g+b)/3), sum in PIX_W+2 bits; all three outputs = gray.
REQ-026 Mode 4: gray as mode 3; all outputs = 2^PIX_W-1 if gray > cfg_value else 0.
REQ-027 Mode 5: each component inverted (2^PIX_W-1 - c).
REQ-028 Modes 6, 7: pass-through.
REQ-029 Simultaneous last-output acceptance and start in the same cycle: start ignored (state not IDLE).

Reset
REQ-030 HRESET high: state IDLE, pipeline emptied; in_ready, out_valid, out_last, busy, done = 0; out_r/g/b, out_row, out_col = 0; latched cfg = 0.
REQ-031 HRESET mid-frame aborts frame immediately; no done pulse; after release, next start begins a fresh frame at row 0, col 0.

Verification
REQ-032 PIX_W=8, 4x2 frame, mode 1, value 100, input r=200,g=50,b=155, out_ready=1 -> outputs 255,150,255; 8 pixels; first out_valid 2 cycles after first accept; out_last on row 1 col 3; done one cycle after.
REQ-033 Mode 3, pixel (10,20,31) -> (20,20,20); mode 4 value 19 -> (255,255,255); value 20 -> (0,0,0).
REQ-034 Mode 2 value 100, pixel (50,100,101) -> (0,0,1); mode 5 pixel (0,255,15) -> (255,0,240).
REQ-035 3x3 frame, random out_ready/in_valid toggling -> 9 outputs in raster order matching model, outputs stable while stalled, in_ready 0 after 9th accept.
REQ-036 start with cfg_width=0 -> done next cycle, no in_ready; start during RUN -> ignored; HRESET after 4 of 9 pixels -> all outputs 0, next frame starts row 0 col 0.
